// File: rtl/neopix_tx_if.sv
// neopix_tx frame-buffer read port.
// The master drives the address; the slave returns data one clock later.
interface neopix_tx_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] RD_ADDR;
  logic [23:0]       RD_DATA;

  modport master (output RD_ADDR, input RD_DATA);
  modport slave  (input RD_ADDR, output RD_DATA);
endinterface

// File: rtl/neopix_tx.sv
// neopix_tx: WS2812 NRZ line driver fed from a synchronous frame buffer.
// Sends NUM_LEDS GRB pixels MSB first, then holds DO low to latch.
module neopix_tx #(
  parameter int NUM_LEDS  = 256,
  parameter int ADDR_W    = 8,
  parameter int T0H_CYC   = 20,
  parameter int T1H_CYC   = 40,
  parameter int BIT_CYC   = 62,
  parameter int LATCH_CYC = 2500
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  output logic        BUSY,
  output logic        DONE,
  output logic        DO,
  neopix_tx_if.master fb
);
  localparam int PH_W = $clog2(BIT_CYC);
  localparam int PX_W = ADDR_W + 1;
  localparam int LC_W = $clog2(LATCH_CYC + 1);

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(BIT_CYC - 1);
  localparam logic [PH_W-1:0] PH_CAP  = PH_W'(2);
  localparam logic [PH_W-1:0] T0H     = PH_W'(T0H_CYC);
  localparam logic [PH_W-1:0] T1H     = PH_W'(T1H_CYC);
  localparam logic [PX_W-1:0] PX_END  = PX_W'(NUM_LEDS);
  localparam logic [PX_W-1:0] PX_LAST = PX_W'(NUM_LEDS - 1);
  localparam logic [LC_W-1:0] LC_LAST = LC_W'(LATCH_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    LATCH
  } state_t;

  state_t            state_q, state_n;
  logic [PH_W-1:0]   ph_q, ph_n;
  logic [4:0]        bit_q, bit_n;
  logic [PX_W-1:0]   px_q, px_n;
  logic [LC_W-1:0]   lc_q, lc_n;
  logic [23:0]       sh_q, sh_n;
  logic [23:0]       pf_q, pf_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic              do_q, do_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign DO        = do_q;
  assign fb.RD_ADDR = addr_q;

  // ph/bit/px describe the bit phase driven onto DO at the next edge;
  // px reaching NUM_LEDS marks the first cycle after the last bit.
  always_comb begin
    state_n = state_q;
    ph_n    = ph_q;
    bit_n   = bit_q;
    px_n    = px_q;
    lc_n    = lc_q;
    sh_n    = sh_q;
    pf_n    = pf_q;
    addr_n  = addr_q;
    do_n    = 1'b0;
    busy_n  = busy_q;
    done_n  = 1'b0;
    unique case (state_q)
      IDLE: begin
        addr_n = '0;
        if (START) begin
          state_n = FETCH;
          busy_n  = 1'b1;
        end
      end
      FETCH: begin
        sh_n    = fb.RD_DATA;
        ph_n    = '0;
        bit_n   = 5'd23;
        px_n    = '0;
        state_n = SEND;
      end
      SEND: begin
        if (px_q == PX_END) begin
          state_n = LATCH;
          addr_n  = '0;
          lc_n    = '0;
        end else begin
          do_n = ph_q < (sh_q[23] ? T1H : T0H);
          if (ph_q == '0 && bit_q == 5'd23 && px_q < PX_LAST)
            addr_n = ADDR_W'(px_q + PX_W'(1));
          // RAM answers the new address two edges after it is issued.
          if (ph_q == PH_CAP && bit_q == 5'd23)
            pf_n = fb.RD_DATA;
          if (ph_q == PH_LAST) begin
            ph_n = '0;
            if (bit_q == '0) begin
              bit_n = 5'd23;
              px_n  = px_q + PX_W'(1);
              sh_n  = pf_q;
            end else begin
              bit_n = bit_q - 5'd1;
              sh_n  = {sh_q[22:0], 1'b0};
            end
          end else begin
            ph_n = ph_q + PH_W'(1);
          end
        end
      end
      LATCH: begin
        if (lc_q == LC_LAST) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          lc_n = lc_q + LC_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      ph_q    <= '0;
      bit_q   <= '0;
      px_q    <= '0;
      lc_q    <= '0;
      sh_q    <= '0;
      pf_q    <= '0;
      addr_q  <= '0;
      do_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      ph_q    <= ph_n;
      bit_q   <= bit_n;
      px_q    <= px_n;
      lc_q    <= lc_n;
      sh_q    <= sh_n;
      pf_q    <= pf_n;
      addr_q  <= addr_n;
      do_q    <= do_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end
endmodule
